// File: rtl/pwrx_pkg.sv
// Shared types and constants for the password receiver: state encoding,
// byte width and the counter-width helper used for idx/fail_count/timer.
package pwrx_pkg;

  localparam int PWRX_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_RESULT,
    S_LOCKED
  } pwrx_state_t;

  // Width needed to hold the values 0..n inclusive.
  function automatic int pwrx_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/password_receiver_if.sv
// Byte-wide password link handshake: the link endpoint is the master,
// the receiver is the slave and returns rx_ready.
interface password_receiver_if;
  import pwrx_pkg::*;

  logic                   rx_valid;
  logic [PWRX_BYTE_W-1:0] rx_byte;
  logic                   rx_last;
  logic                   rx_ready;

  modport master (output rx_valid, output rx_byte, output rx_last, input rx_ready);
  modport slave  (input rx_valid, input rx_byte, input rx_last, output rx_ready);

endinterface

// File: rtl/pwrx_lockout_timer.sv
// Lockout down-counter: load presets LOCKOUT_CYCLES-1, en decrements toward
// zero, done flags zero so the owner stays locked exactly LOCKOUT_CYCLES cycles.
module pwrx_lockout_timer
  import pwrx_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = pwrx_cnt_w(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/password_receiver.sv
// Framed password receiver with fixed-time compare and pass/fail pulses.
// Define PWRX_LOCKOUT_EN to build failed-attempt counting and the LOCKED state.
module password_receiver
  import pwrx_pkg::*;
#(
  parameter int PW_BYTES       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              reset_n,
  password_receiver_if.slave                rx,
  input  logic [PWRX_BYTE_W*PW_BYTES-1:0]   expected_pw,
  output logic                              auth_ok,
  output logic                              auth_fail,
  output logic                              locked,
  output logic [pwrx_cnt_w(MAX_FAILS)-1:0]  fail_count
);

  localparam int IDX_W = pwrx_cnt_w(PW_BYTES);
  localparam int FC_W  = pwrx_cnt_w(MAX_FAILS);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PW_BYTES);

  if (PW_BYTES < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("password_receiver: PW_BYTES, MAX_FAILS and LOCKOUT_CYCLES must be >= 1");
  end

  pwrx_state_t            state_q, state_d;
  logic [PWRX_BYTE_W-1:0] diff_q, diff_d;
  logic [PWRX_BYTE_W-1:0] exp_byte;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   auth_ok_q, auth_ok_d;
  logic                   auth_fail_q, auth_fail_d;
  logic                   accept;
  logic                   pass;

`ifdef PWRX_LOCKOUT_EN
  localparam logic [FC_W-1:0] FAIL_MAX = FC_W'(MAX_FAILS);

  logic [FC_W-1:0] fail_count_q, fail_count_d, fail_next;
  logic            locked_q, locked_d;
  logic            timer_load, timer_en, timer_done;

  pwrx_lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (timer_load),
    .en    (timer_en),
    .done  (timer_done)
  );
`endif

  assign accept = rx.rx_valid && rx_ready_q;
  // diff/idx/ovf are held through CHECK and RESULT, so pass stays valid there.
  assign pass   = (diff_q == '0) && !ovf_q && (idx_q == IDX_FULL);

  // Full mux over every secret byte so selection time never depends on idx.
  always_comb begin
    exp_byte = '0;
    for (int i = 0; i < PW_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        exp_byte = expected_pw[i*PWRX_BYTE_W +: PWRX_BYTE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    diff_d      = diff_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    rx_ready_d  = rx_ready_q;
    auth_ok_d   = 1'b0;
    auth_fail_d = 1'b0;
`ifdef PWRX_LOCKOUT_EN
    fail_count_d = fail_count_q;
    fail_next    = fail_count_q + 1'b1;
    locked_d     = locked_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          if (idx_q < IDX_FULL) begin
            diff_d = diff_q | (rx.rx_byte ^ exp_byte);
            idx_d  = idx_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (rx.rx_last) begin
            state_d    = S_CHECK;
            rx_ready_d = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_CHECK: begin
        state_d     = S_RESULT;
        auth_ok_d   = pass;
        auth_fail_d = !pass;
      end
      S_RESULT: begin
        // Zeroize the compare state on the way out of every frame.
        diff_d     = '0;
        idx_d      = '0;
        ovf_d      = 1'b0;
        state_d    = S_IDLE;
        rx_ready_d = 1'b1;
`ifdef PWRX_LOCKOUT_EN
        if (pass) begin
          fail_count_d = '0;
        end else begin
          fail_count_d = fail_next;
          if (fail_next == FAIL_MAX) begin
            state_d    = S_LOCKED;
            rx_ready_d = 1'b0;
            locked_d   = 1'b1;
            timer_load = 1'b1;
          end
        end
`endif
      end
      S_LOCKED: begin
`ifdef PWRX_LOCKOUT_EN
        if (timer_done) begin
          state_d      = S_IDLE;
          rx_ready_d   = 1'b1;
          locked_d     = 1'b0;
          fail_count_d = '0;
        end else begin
          timer_en = 1'b1;
        end
`else
        state_d    = S_IDLE;
        rx_ready_d = 1'b1;
`endif
      end
      default: begin
        state_d    = S_IDLE;
        diff_d     = '0;
        idx_d      = '0;
        ovf_d      = 1'b0;
        rx_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      diff_q       <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      rx_ready_q   <= 1'b1;
      auth_ok_q    <= 1'b0;
      auth_fail_q  <= 1'b0;
`ifdef PWRX_LOCKOUT_EN
      fail_count_q <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      diff_q       <= diff_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      rx_ready_q   <= rx_ready_d;
      auth_ok_q    <= auth_ok_d;
      auth_fail_q  <= auth_fail_d;
`ifdef PWRX_LOCKOUT_EN
      fail_count_q <= fail_count_d;
      locked_q     <= locked_d;
`endif
    end
  end

  assign rx.rx_ready = rx_ready_q;
  assign auth_ok     = auth_ok_q;
  assign auth_fail   = auth_fail_q;
`ifdef PWRX_LOCKOUT_EN
  assign locked      = locked_q;
  assign fail_count  = fail_count_q;
`else
  assign locked      = 1'b0;
  assign fail_count  = '0;
`endif

endmodule

// File: tb/tb_password_receiver.sv
// Randomized self-checking bench for password_receiver against a frame-level
// reference model (whole-frame equality, attempt counting, lockout length).
module tb_password_receiver;
  import pwrx_pkg::*;

  localparam int PW  = 4;
  localparam int MF  = 3;
  localparam int LC  = 256;
  localparam int FCW = pwrx_cnt_w(MF);

  logic            clk = 1'b0;
  logic            reset_n;
  logic [8*PW-1:0] expected_pw;
  logic            auth_ok, auth_fail, locked;
  logic [FCW-1:0]  fail_count;

  int checks = 0;
  int errors = 0;
  int model_fail = 0;
  logic [7:0] frame_q[$];

  password_receiver_if rx_if();

  password_receiver #(
    .PW_BYTES       (PW),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx_if),
    .expected_pw (expected_pw),
    .auth_ok     (auth_ok),
    .auth_fail   (auth_fail),
    .locked      (locked),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A frame authenticates only if it is exactly the secret, byte for byte.
  function automatic bit frame_passes();
    if (frame_q.size() != PW) return 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (frame_q[i] != expected_pw[8*i +: 8]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rdy"},    rx_if.rx_ready, 1);
    check_eq({tag, "_ok"},     auth_ok, 0);
    check_eq({tag, "_fail"},   auth_fail, 0);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_fc"},     fail_count, 0);
  endtask

  task automatic wait_lockout(input string tag);
    int cyc = 0;
    while (locked === 1'b1 && cyc < LC + 8) begin
      check_eq({tag, "_lock_rdy"}, rx_if.rx_ready, 0);
      rx_if.rx_valid = 1'($urandom_range(0, 1));
      rx_if.rx_byte  = 8'($urandom);
      rx_if.rx_last  = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
    check_eq({tag, "_lock_len"},  cyc, LC);
    check_eq({tag, "_lock_xrdy"}, rx_if.rx_ready, 1);
    check_eq({tag, "_lock_xfc"},  fail_count, 0);
    model_fail = 0;
  endtask

  task automatic send_frame(input string tag);
    bit exp_pass;
    bit exp_lock;
    int gap;
    exp_pass = frame_passes();
    for (int i = 0; i < frame_q.size(); i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        rx_if.rx_last = 1'($urandom_range(0, 1));
        rx_if.rx_byte = 8'($urandom);
        tick();
      end
      check_eq({tag, "_rdy"}, rx_if.rx_ready, 1);
      rx_if.rx_valid = 1'b1;
      rx_if.rx_byte  = frame_q[i];
      rx_if.rx_last  = (i == frame_q.size() - 1);
      tick();
      rx_if.rx_valid = 1'b0;
      rx_if.rx_last  = 1'b0;
    end
    // Cycle N+1: CHECK; stray traffic must be ignored.
    check_eq({tag, "_n1_ok"},   auth_ok, 0);
    check_eq({tag, "_n1_fail"}, auth_fail, 0);
    check_eq({tag, "_n1_rdy"},  rx_if.rx_ready, 0);
    rx_if.rx_valid = 1'($urandom_range(0, 1));
    rx_if.rx_byte  = 8'($urandom);
    rx_if.rx_last  = 1'($urandom_range(0, 1));
    tick();
    // Cycle N+2: result pulse.
    check_eq({tag, "_n2_ok"},   auth_ok, exp_pass);
    check_eq({tag, "_n2_fail"}, auth_fail, !exp_pass);
    check_eq({tag, "_n2_rdy"},  rx_if.rx_ready, 0);
`ifdef PWRX_LOCKOUT_EN
    if (exp_pass) model_fail = 0;
    else          model_fail++;
    exp_lock = (model_fail == MF);
`else
    exp_lock = 1'b0;
`endif
    tick();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
    // Cycle N+3: pulse gone, idle again or locked.
    check_eq({tag, "_n3_ok"},     auth_ok, 0);
    check_eq({tag, "_n3_fail"},   auth_fail, 0);
    check_eq({tag, "_n3_fc"},     fail_count, model_fail);
    check_eq({tag, "_n3_locked"}, locked, exp_lock);
    check_eq({tag, "_n3_rdy"},    rx_if.rx_ready, !exp_lock);
    if (exp_lock) wait_lockout(tag);
  endtask

  initial begin
    int kind;
    int p;
    int n;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
    rx_if.rx_last  = 1'b0;
    expected_pw    = 32'h44_33_22_11;
    reset_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    frame_q = {8'h11, 8'h22, 8'h33, 8'h44};        send_frame("pass");
    frame_q = {8'h11, 8'h22, 8'h99, 8'h44};        send_frame("bad_b2");
    frame_q = {8'h00, 8'h22, 8'h33, 8'h44};        send_frame("bad_b0");
    frame_q = {8'h11, 8'h22, 8'h33, 8'h44};        send_frame("pass_clr");
    frame_q = {8'h11, 8'h22, 8'h33};               send_frame("short");
    frame_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; send_frame("long");
    frame_q = {8'h11};                             send_frame("one_byte");
    frame_q = {8'h11, 8'h22, 8'h33, 8'h44};        send_frame("post_lock");

    // Reset in the middle of a frame, with a nonzero failure count pending.
    frame_q = {8'h11, 8'h22, 8'h33, 8'h45};        send_frame("pre_rst");
    rx_if.rx_valid = 1'b1;
    rx_if.rx_byte  = 8'h11;
    tick();
    rx_if.rx_byte  = 8'h22;
    tick();
    rx_if.rx_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_fail = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("midrst_nopulse", {30'd0, auth_ok, auth_fail}, 0);
      tick();
    end
    frame_q = {8'h11, 8'h22, 8'h33, 8'h44};        send_frame("after_rst");

    // Randomized frames against randomized secrets.
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < PW; b++) expected_pw[8*b +: 8] = 8'($urandom);
      kind = $urandom_range(0, 4);
      frame_q.delete();
      case (kind)
        0, 1: begin
          for (int b = 0; b < PW; b++) frame_q.push_back(expected_pw[8*b +: 8]);
          if (kind == 1) begin
            p = $urandom_range(0, PW - 1);
            frame_q[p] = frame_q[p] ^ 8'($urandom_range(1, 255));
          end
        end
        2: begin
          n = $urandom_range(1, PW - 1);
          for (int b = 0; b < n; b++) frame_q.push_back(expected_pw[8*b +: 8]);
        end
        3: begin
          for (int b = 0; b < PW; b++) frame_q.push_back(expected_pw[8*b +: 8]);
          n = $urandom_range(1, 2);
          for (int b = 0; b < n; b++) frame_q.push_back(8'($urandom));
        end
        default: begin
          n = $urandom_range(1, 6);
          for (int b = 0; b < n; b++) frame_q.push_back(8'($urandom));
        end
      endcase
      send_frame("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/password_receiver.md
# password_receiver

Receiving end of the byte-wide cleartext password link. Accepts a framed password one byte per handshake and compares it against a provisioned secret using a fixed-time compare (no early exit). Reports pass/fail pulses and enforces a failed-attempt lockout. Sits between the link endpoint and the unlock/privilege logic.

## Interface
- PW_BYTES, 4, password length in bytes (≥1)
- MAX_FAILS, 3, consecutive failures that trigger lockout (≥1)
- LOCKOUT_CYCLES, 256, clock cycles spent in lockout (≥1)
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  byte present on rx_byte
- rx_byte  in  8  password byte
- rx_last  in  1  final byte of frame; qualified by rx_valid
- expected_pw  in  8*PW_BYTES  provisioned secret; byte i at [8i+7:8i]; first received byte matches i=0
- rx_ready  out  1  receiver can accept a byte
- auth_ok  out  1  one-cycle pass pulse
- auth_fail  out  1  one-cycle fail pulse
- locked  out  1  lockout active
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures

## Operation
- Byte accepted on a rising edge where rx_valid && rx_ready.
- States: IDLE, COLLECT, CHECK, RESULT, LOCKED.
- IDLE: rx_ready=1. Accept byte → fold into compare, idx=1, go COLLECT; or go CHECK if rx_last.
- COLLECT: rx_ready=1. Each accepted byte: idx++ (saturating at PW_BYTES), fold into compare; rx_last → CHECK.
- Compare fold: diff |= rx_byte ^ expected_pw byte[idx] while idx<PW_BYTES. A byte at idx ≥ PW_BYTES sets ovf and is not compared.
- Final byte count = number of accepted bytes in the frame, including the rx_last byte.
- CHECK: rx_ready=0. pass = (diff==0) && !ovf && count==PW_BYTES.
- RESULT: rx_ready=0. auth_ok=pass, auth_fail=!pass for this cycle only.
- RESULT, pass → fail_count=0; next state IDLE.
- RESULT, fail → fail_count++; if new count==MAX_FAILS, go LOCKED, else IDLE.
- LOCKED: rx_ready=0, locked=1. Timer counts LOCKOUT_CYCLES cycles, then fail_count=0 and state IDLE.
- diff, idx, ovf are cleared on every entry to IDLE (zeroize).
- No received byte is stored beyond the diff accumulator.
- rx_valid while rx_ready=0 is ignored; there is no backpressure buffering.

## Timing
- Reset values: rx_ready=1, auth_ok=0, auth_fail=0, locked=0, fail_count=0, state IDLE, diff/idx/ovf/timer 0.
- rx_last byte accepted at edge N: CHECK during cycle N+1; auth_ok/auth_fail high during cycle N+2; rx_ready high again from cycle N+3.
- Lockout: locked rises the cycle after the failing RESULT. It stays high exactly LOCKOUT_CYCLES cycles. rx_ready is high the cycle after locked falls.
- Compare latency is independent of which byte mismatches.
- rx_last with rx_valid on the first byte of a frame is a 1-byte frame; it passes only if PW_BYTES==1.
- fail_count never exceeds MAX_FAILS.
- Async reset mid-frame or mid-lockout aborts the operation with no result pulse; all state returns to reset values.

## Configuration
- PWRX_LOCKOUT_EN defined: fail counting and LOCKED state as described.
- PWRX_LOCKOUT_EN undefined:
  - LOCKED state, timer and counter are not built.
  - locked is tied 0 and fail_count is tied 0.
  - RESULT always returns to IDLE; unlimited attempts.

## Structure
- Shared package pwrx_pkg holds:
  - state enum pwrx_state_t
  - byte width constant PWRX_BYTE_W=8
  - width helper for idx/fail_count
- Sub-module pwrx_lockout_timer: load/enable/done down-counter of width $clog2(LOCKOUT_CYCLES+1), instantiated only under PWRX_LOCKOUT_EN.

## Test plan
- expected_pw=32'h44_33_22_11; send 11,22,33,44 with rx_last on 44 → auth_ok pulse at N+2; fail_count stays 0.
- Same secret; send 11,22,99,44 → auth_fail; fail_count=1. Repeat with mismatch on byte 0 → identical pulse cycle N+2.
- Short frame 11,22,33 with rx_last → auth_fail.
- Long frame 11,22,33,44,55 with rx_last → auth_fail (ovf).
- Three consecutive wrong frames with defaults:
  - locked=1 for 256 cycles; rx_ready=0 and rx_valid ignored during lockout.
  - Afterwards fail_count=0; a correct frame then gives auth_ok.
- Assert reset_n low after two bytes of a frame → no pulse; all outputs at reset values. A following full correct frame → auth_ok.
